// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, write-router FSM states and the
// default sixteen-slave address map.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, W_CAPT, SL_REQ, SL_RESP, M_RESP} wr_state_t;

    localparam logic [31:0] DEFAULT_ADDR_OFFSET [16] = '{
        32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000,
        32'h4000_0000, 32'h5000_0000, 32'h6000_0000, 32'h7000_0000,
        32'h8000_0000, 32'h9000_0000, 32'hA000_0000, 32'hB000_0000,
        32'hC000_0000, 32'hD000_0000, 32'hE000_0000, 32'hF000_0000
    };

    localparam logic [31:0] DEFAULT_ADDR_RANGE [16] = '{default: 32'h0000_FFFF};

endpackage

// File: rtl/axi_lite_addr_decoder.sv
// Combinational address decoder: maps an address onto a slave index, lowest
// matching window first, or flags a miss when no window contains it.
module axi_lite_addr_decoder
    import axi_lite_pkg::*;
#(
    parameter int unsigned NUMBER_SLAVE   = 16,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned SEL_W          = (NUMBER_SLAVE > 1) ? $clog2(NUMBER_SLAVE) : 1,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET [NUMBER_SLAVE] = DEFAULT_ADDR_OFFSET,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  [NUMBER_SLAVE] = DEFAULT_ADDR_RANGE
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic [SEL_W-1:0]          sel,
    output logic                      miss
);

    logic [AXI_ADDR_WIDTH:0] addr_x;
    logic [AXI_ADDR_WIDTH:0] lo_x;
    logic [AXI_ADDR_WIDTH:0] hi_x;

    // One extra bit so a window ending at the top of the address space cannot wrap.
    always_comb begin
        sel    = '0;
        miss   = 1'b1;
        addr_x = {1'b0, addr};
        lo_x   = '0;
        hi_x   = '0;
        for (int unsigned i = 0; i < NUMBER_SLAVE; i++) begin
            lo_x = {1'b0, AXI_ADDR_OFFSET[i]};
            hi_x = {1'b0, AXI_ADDR_OFFSET[i]} + {1'b0, AXI_ADDR_RANGE[i]};
            if (miss && (addr_x >= lo_x) && (addr_x <= hi_x)) begin
                sel  = i[SEL_W-1:0];
                miss = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_lite_wr_router.sv
// Single-master to multi-slave AXI-Lite write router: one write in flight,
// DECERR for unmapped addresses, SLVERR when the selected slave stalls too long.
module axi_lite_wr_router
    import axi_lite_pkg::*;
#(
    parameter int unsigned NUMBER_SLAVE   = 16,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET [NUMBER_SLAVE] = DEFAULT_ADDR_OFFSET,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  [NUMBER_SLAVE] = DEFAULT_ADDR_RANGE,
    parameter int unsigned TIMEOUT_CYCLES = 150
) (
    input  logic                                     aclk,
    input  logic                                     areset,
    input  logic [AXI_ADDR_WIDTH-1:0]                s_awaddr,
    input  logic                                     s_awvalid,
    output logic                                     s_awready,
    input  logic [AXI_DATA_WIDTH-1:0]                s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]              s_wstrb,
    input  logic                                     s_wvalid,
    output logic                                     s_wready,
    output logic [1:0]                               s_bresp,
    output logic                                     s_bvalid,
    input  logic                                     s_bready,
    output logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0]   m_awaddr,
    output logic [NUMBER_SLAVE-1:0]                  m_awvalid,
    input  logic [NUMBER_SLAVE-1:0]                  m_awready,
    output logic [NUMBER_SLAVE*AXI_DATA_WIDTH-1:0]   m_wdata,
    output logic [NUMBER_SLAVE*AXI_DATA_WIDTH/8-1:0] m_wstrb,
    output logic [NUMBER_SLAVE-1:0]                  m_wvalid,
    input  logic [NUMBER_SLAVE-1:0]                  m_wready,
    input  logic [NUMBER_SLAVE*2-1:0]                m_bresp,
    input  logic [NUMBER_SLAVE-1:0]                  m_bvalid,
    output logic [NUMBER_SLAVE-1:0]                  m_bready
);

    localparam int unsigned SEL_W = (NUMBER_SLAVE > 1) ? $clog2(NUMBER_SLAVE) : 1;
    localparam int unsigned SW    = AXI_DATA_WIDTH / 8;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    wr_state_t                 state;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] data_q;
    logic [SW-1:0]             strb_q;
    logic [SEL_W-1:0]          sel_q;
    logic                      miss_q;
    logic [1:0]                bresp_q;
    logic                      aw_done;
    logic                      w_done;
    logic [CNT_W-1:0]          tmo_cnt;

    logic [SEL_W-1:0] dec_sel;
    logic             dec_miss;
    logic             sel_awready, sel_wready, sel_bvalid;
    logic [1:0]       sel_bresp;
    logic             sl_aw_hs, sl_w_hs, sl_b_hs, tmo_hit;

    axi_lite_addr_decoder #(
        .NUMBER_SLAVE    (NUMBER_SLAVE),
        .AXI_ADDR_WIDTH  (AXI_ADDR_WIDTH),
        .SEL_W           (SEL_W),
        .AXI_ADDR_OFFSET (AXI_ADDR_OFFSET),
        .AXI_ADDR_RANGE  (AXI_ADDR_RANGE)
    ) u_dec (
        .addr (s_awaddr),
        .sel  (dec_sel),
        .miss (dec_miss)
    );

    assign s_awready = (state == IDLE) && !areset;
    assign s_wready  = (state == W_CAPT);
    assign s_bvalid  = (state == M_RESP);
    assign s_bresp   = bresp_q;

    always_comb begin
        m_awaddr    = '0;
        m_awvalid   = '0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_wvalid    = '0;
        m_bready    = '0;
        sel_awready = 1'b0;
        sel_wready  = 1'b0;
        sel_bvalid  = 1'b0;
        sel_bresp   = RESP_OKAY;
        for (int unsigned i = 0; i < NUMBER_SLAVE; i++) begin
            if (!miss_q && (sel_q == i[SEL_W-1:0])) begin
                m_awaddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] = addr_q;
                m_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]  = data_q;
                m_wstrb[i*SW +: SW]                          = strb_q;
                m_awvalid[i] = (state == SL_REQ) && !aw_done;
                m_wvalid[i]  = (state == SL_REQ) && !w_done;
                m_bready[i]  = (state == SL_RESP);
                sel_awready  = m_awready[i];
                sel_wready   = m_wready[i];
                sel_bvalid   = m_bvalid[i];
                sel_bresp    = m_bresp[i*2 +: 2];
            end
        end
    end

    assign sl_aw_hs = (state == SL_REQ) && !aw_done && sel_awready;
    assign sl_w_hs  = (state == SL_REQ) && !w_done && sel_wready;
    assign sl_b_hs  = (state == SL_RESP) && sel_bvalid;
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && ((state == SL_REQ) || (state == SL_RESP))
                      && (tmo_cnt == TMO_LAST);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            sel_q   <= '0;
            miss_q  <= 1'b0;
            bresp_q <= RESP_OKAY;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_awvalid) begin
                        addr_q <= s_awaddr;
                        sel_q  <= dec_sel;
                        miss_q <= dec_miss;
                        state  <= W_CAPT;
                    end
                end
                W_CAPT: begin
                    if (s_wvalid) begin
                        data_q  <= s_wdata;
                        strb_q  <= s_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        tmo_cnt <= '0;
                        if (miss_q) begin
                            bresp_q <= RESP_DECERR;
                            state   <= M_RESP;
                        end else begin
                            state <= SL_REQ;
                        end
                    end
                end
                SL_REQ: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (sl_aw_hs) aw_done <= 1'b1;
                    if (sl_w_hs)  w_done  <= 1'b1;
                    if (tmo_hit) begin
                        bresp_q <= RESP_SLVERR;
                        state   <= M_RESP;
                    end else if ((aw_done || sl_aw_hs) && (w_done || sl_w_hs)) begin
                        state <= SL_RESP;
                    end
                end
                SL_RESP: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // A B handshake coinciding with expiry still returns the slave's answer.
                    if (sl_b_hs) begin
                        bresp_q <= sel_bresp;
                        state   <= M_RESP;
                    end else if (tmo_hit) begin
                        bresp_q <= RESP_SLVERR;
                        state   <= M_RESP;
                    end
                end
                M_RESP: begin
                    if (s_bready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_wr_router.sv
// Directed testbench for axi_lite_wr_router with a scripted slave-side model.
module tb_axi_lite_wr_router;

    localparam int NS = 16;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic [AW-1:0]     s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [NS*AW-1:0]  m_awaddr;
    logic [NS-1:0]     m_awvalid;
    logic [NS-1:0]     m_awready;
    logic [NS*DW-1:0]  m_wdata;
    logic [NS*SW-1:0]  m_wstrb;
    logic [NS-1:0]     m_wvalid;
    logic [NS-1:0]     m_wready;
    logic [NS*2-1:0]   m_bresp;
    logic [NS-1:0]     m_bvalid;
    logic [NS-1:0]     m_bready;

    int checks = 0;
    int passed = 0;

    axi_lite_wr_router #(
        .NUMBER_SLAVE   (NS),
        .AXI_DATA_WIDTH (DW),
        .AXI_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (150)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    // Slave model: one slave answers AW/W immediately and optionally drives B.
    task automatic set_slave(input int idx, input logic bv, input logic [1:0] br);
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bresp   = '0;
        m_awready[idx]     = 1'b1;
        m_wready[idx]      = 1'b1;
        m_bvalid[idx]      = bv;
        m_bresp[idx*2 +: 2] = br;
    endtask

    // Issues AW then W on consecutive cycles; returns two cycles after AW.
    task automatic drive_aw_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        s_awaddr  = a;
        s_awvalid = 1'b1;
        s_wdata   = d;
        s_wstrb   = s;
        s_wvalid  = 1'b0;
        tick;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b1;
        tick;
        s_wvalid  = 1'b0;
    endtask

    task automatic finish_b;
        s_bready = 1'b1;
        tick;
        s_bready = 1'b0;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        #12;
        checks++; if ({s_awready, s_wready, s_bvalid} !== 3'b000) $display("FAIL reset_ready_valid got %b want 000", {s_awready, s_wready, s_bvalid}); else passed++;
        checks++; if (s_bresp !== 2'b00) $display("FAIL reset_bresp got %b want 00", s_bresp); else passed++;
        checks++; if ({m_awvalid, m_wvalid, m_bready} !== '0) $display("FAIL reset_m_valid got %h want 0", {m_awvalid, m_wvalid, m_bready}); else passed++;
        checks++; if ({m_awaddr, m_wdata, m_wstrb} !== '0) $display("FAIL reset_m_payload got nonzero want 0"); else passed++;
        @(negedge aclk);
        areset = 1'b0;
        tick;
        checks++; if (s_awready !== 1'b1) $display("FAIL reset_idle_awready got %b want 1", s_awready); else passed++;
    endtask

    task automatic test_basic;
        logic [NS*AW-1:0] amask;
        logic [NS*DW-1:0] dmask;
        amask = '0; amask[3*AW +: AW] = '1;
        dmask = '0; dmask[3*DW +: DW] = '1;
        set_slave(3, 1'b1, 2'b00);
        s_awaddr = 32'h3000_0010; s_awvalid = 1'b1;
        s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1'b0;
        tick;
        s_awvalid = 1'b0; s_wvalid = 1'b1;
        checks++; if ({s_awready, s_wready} !== 2'b01) $display("FAIL basic_wcapt_ready got %b want 01", {s_awready, s_wready}); else passed++;
        checks++; if (m_awvalid !== '0) $display("FAIL basic_early_awvalid got %h want 0", m_awvalid); else passed++;
        tick;
        s_wvalid = 1'b0;
        checks++; if (m_awvalid !== 16'h0008) $display("FAIL basic_awvalid got %h want 0008", m_awvalid); else passed++;
        checks++; if (m_wvalid !== 16'h0008) $display("FAIL basic_wvalid got %h want 0008", m_wvalid); else passed++;
        checks++; if (m_awaddr[3*AW +: AW] !== 32'h3000_0010) $display("FAIL basic_awaddr got %h want 30000010", m_awaddr[3*AW +: AW]); else passed++;
        checks++; if (m_wdata[3*DW +: DW] !== 32'hDEAD_BEEF) $display("FAIL basic_wdata got %h want deadbeef", m_wdata[3*DW +: DW]); else passed++;
        checks++; if (m_wstrb[3*SW +: SW] !== 4'hF) $display("FAIL basic_wstrb got %h want f", m_wstrb[3*SW +: SW]); else passed++;
        checks++; if (((m_awaddr & ~amask) !== '0) || ((m_wdata & ~dmask) !== '0)) $display("FAIL basic_other_slices got nonzero want 0"); else passed++;
        tick;
        checks++; if ({m_awvalid, m_wvalid} !== '0 || m_bready !== 16'h0008) $display("FAIL basic_sl_resp got aw=%h w=%h b=%h want 0/0/0008", m_awvalid, m_wvalid, m_bready); else passed++;
        tick;
        checks++; if ({s_bvalid, s_bresp} !== 3'b100) $display("FAIL basic_bresp got %b want 100", {s_bvalid, s_bresp}); else passed++;
        finish_b;
        checks++; if ({s_bvalid, s_awready} !== 2'b01) $display("FAIL basic_back_idle got %b want 01", {s_bvalid, s_awready}); else passed++;
    endtask

    task automatic test_decerr;
        set_slave(3, 1'b1, 2'b00);
        drive_aw_w(32'h3001_0000, 32'h1111_2222, 4'hF);
        checks++; if ({m_awvalid, m_wvalid} !== '0) $display("FAIL decerr_no_valid got %h want 0", {m_awvalid, m_wvalid}); else passed++;
        checks++; if ({s_bvalid, s_bresp} !== 3'b111) $display("FAIL decerr_bresp got %b want 111", {s_bvalid, s_bresp}); else passed++;
        finish_b;
    endtask

    task automatic test_timeout;
        int early_b;
        int bad_bready;
        early_b = 0;
        bad_bready = 0;
        set_slave(5, 1'b0, 2'b00);
        drive_aw_w(32'h5000_0040, 32'h0BAD_F00D, 4'hF);
        for (int i = 0; i < 150; i++) begin
            if (s_bvalid !== 1'b0) early_b++;
            if (i >= 1 && m_bready !== 16'h0020) bad_bready++;
            tick;
        end
        checks++; if (early_b != 0) $display("FAIL timeout_early_bvalid got %0d cycles want 0", early_b); else passed++;
        checks++; if (bad_bready != 0) $display("FAIL timeout_bready_wait got %0d bad cycles want 0", bad_bready); else passed++;
        checks++; if ({s_bvalid, s_bresp} !== 3'b110) $display("FAIL timeout_bresp got %b want 110", {s_bvalid, s_bresp}); else passed++;
        checks++; if ({m_awvalid, m_wvalid, m_bready} !== '0) $display("FAIL timeout_drop got %h want 0", {m_awvalid, m_wvalid, m_bready}); else passed++;
        m_bvalid[5] = 1'b1;
        #1;
        checks++; if (m_bready !== '0) $display("FAIL timeout_late_b_mresp got %h want 0", m_bready); else passed++;
        finish_b;
        tick;
        checks++; if ({s_awready, s_bvalid} !== 2'b10 || m_bready !== '0) $display("FAIL timeout_late_b_idle got aw=%b b=%b br=%h want 1/0/0", s_awready, s_bvalid, m_bready); else passed++;
        m_bvalid[5] = 1'b0;
    endtask

    task automatic test_w_before_aw;
        int early_w;
        early_w = 0;
        set_slave(1, 1'b1, 2'b00);
        s_wdata = 32'h1234_5678; s_wstrb = 4'h3; s_wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (s_wready !== 1'b0) early_w++;
            tick;
        end
        s_awaddr = 32'h1000_0004; s_awvalid = 1'b1;
        if (s_wready !== 1'b0) early_w++;
        tick;
        s_awvalid = 1'b0;
        checks++; if (early_w != 0) $display("FAIL wfirst_held_off got %0d ready cycles want 0", early_w); else passed++;
        checks++; if (s_wready !== 1'b1) $display("FAIL wfirst_wready got %b want 1", s_wready); else passed++;
        tick;
        s_wvalid = 1'b0;
        checks++; if (m_wvalid !== 16'h0002 || m_wdata[1*DW +: DW] !== 32'h1234_5678 || m_wstrb[1*SW +: SW] !== 4'h3) $display("FAIL wfirst_payload got v=%h d=%h s=%h want 0002/12345678/3", m_wvalid, m_wdata[1*DW +: DW], m_wstrb[1*SW +: SW]); else passed++;
        checks++; if (m_awaddr[1*AW +: AW] !== 32'h1000_0004) $display("FAIL wfirst_awaddr got %h want 10000004", m_awaddr[1*AW +: AW]); else passed++;
        tick;
        tick;
        checks++; if ({s_bvalid, s_bresp} !== 3'b100) $display("FAIL wfirst_bresp got %b want 100", {s_bvalid, s_bresp}); else passed++;
        finish_b;
    endtask

    task automatic test_bready_stall;
        int bad;
        bad = 0;
        set_slave(2, 1'b1, 2'b10);
        drive_aw_w(32'h2000_0008, 32'h5555_AAAA, 4'hC);
        tick;
        tick;
        s_awaddr = 32'h0000_0000; s_awvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (s_bvalid !== 1'b1 || s_bresp !== 2'b10 || s_awready !== 1'b0) bad++;
            tick;
        end
        checks++; if (bad != 0) $display("FAIL stall_stable got %0d bad cycles want 0", bad); else passed++;
        s_awvalid = 1'b0;
        finish_b;
        checks++; if (s_bvalid !== 1'b0) $display("FAIL stall_release got %b want 0", s_bvalid); else passed++;
    endtask

    task automatic test_reset_mid;
        set_slave(0, 1'b0, 2'b00);
        drive_aw_w(32'h0000_0100, 32'h7777_8888, 4'hF);
        tick;
        checks++; if (m_bready !== 16'h0001) $display("FAIL rstmid_in_slresp got %h want 0001", m_bready); else passed++;
        areset = 1'b1;
        #1;
        checks++; if ({s_awready, s_wready, s_bvalid, s_bresp} !== 5'b0) $display("FAIL rstmid_s_outputs got %b want 00000", {s_awready, s_wready, s_bvalid, s_bresp}); else passed++;
        checks++; if ({m_awvalid, m_wvalid, m_bready} !== '0 || {m_awaddr, m_wdata, m_wstrb} !== '0) $display("FAIL rstmid_m_outputs got nonzero want 0"); else passed++;
        #2;
        areset = 1'b0;
        tick;
        checks++; if (s_awready !== 1'b1) $display("FAIL rstmid_idle got %b want 1", s_awready); else passed++;
        m_bvalid[0] = 1'b1;
        drive_aw_w(32'h0000_0200, 32'h0000_CAFE, 4'hF);
        checks++; if (m_awvalid !== 16'h0001 || m_awaddr[AW-1:0] !== 32'h0000_0200) $display("FAIL rstmid_retry_aw got v=%h a=%h want 0001/00000200", m_awvalid, m_awaddr[AW-1:0]); else passed++;
        tick;
        tick;
        checks++; if ({s_bvalid, s_bresp} !== 3'b100) $display("FAIL rstmid_retry_bresp got %b want 100", {s_bvalid, s_bresp}); else passed++;
        finish_b;
    endtask

    task automatic test_top_window;
        set_slave(15, 1'b1, 2'b00);
        drive_aw_w(32'hF000_FFFF, 32'hFEED_FACE, 4'hF);
        checks++; if (m_awvalid !== 16'h8000 || m_awaddr[15*AW +: AW] !== 32'hF000_FFFF) $display("FAIL top_route got v=%h a=%h want 8000/f000ffff", m_awvalid, m_awaddr[15*AW +: AW]); else passed++;
        tick;
        tick;
        checks++; if ({s_bvalid, s_bresp} !== 3'b100) $display("FAIL top_bresp got %b want 100", {s_bvalid, s_bresp}); else passed++;
        finish_b;
        drive_aw_w(32'hF001_0000, 32'h0, 4'h0);
        checks++; if ({s_bvalid, s_bresp} !== 3'b111 || m_awvalid !== '0) $display("FAIL top_past_end got %b v=%h want 111/0", {s_bvalid, s_bresp}, m_awvalid); else passed++;
        finish_b;
    endtask

    initial begin
        s_awaddr = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0;
        m_awready = '0; m_wready = '0; m_bvalid = '0; m_bresp = '0;
        test_reset;
        test_basic;
        test_decerr;
        test_timeout;
        test_w_before_aw;
        test_bready_stall;
        test_reset_mid;
        test_top_window;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
